// File: rtl/div_pkg.sv
// Shared types and sizing for the 16-bit sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH  = 16;
    localparam int STEP_WIDTH = DIV_WIDTH + 1;
    localparam int CNT_WIDTH  = $clog2(DIV_WIDTH);

    typedef logic [DIV_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/cla_adder.sv
// Team carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla_adder #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Each carry inside a group is a direct function of the group's carry-in.
    always_comb begin
        logic run_g;
        logic run_p;
        logic grp_c;
        carry    = '0;
        carry[0] = cin_i;
        run_g    = 1'b0;
        run_p    = 1'b1;
        grp_c    = cin_i;
        for (int k = 0; k < WIDTH; k++) begin
            if (k % 4 == 0) begin
                run_g = 1'b0;
                run_p = 1'b1;
                grp_c = carry[k];
            end
            run_g        = gen[k] | (prop[k] & run_g);
            run_p        = run_p & prop[k];
            carry[k+1]   = run_g | (run_p & grp_c);
        end
    end

    assign sum_o  = prop ^ carry[WIDTH-1:0];
    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/div_sub_step.sv
// One restoring-division step: 17-bit trial subtract (a + ~b + 1) and restore select.
module div_sub_step
    import div_pkg::*;
(
    input  logic [STEP_WIDTH-1:0] minuend_i,
    input  word_t                 divisor_i,
    output word_t                 rem_o,
    output logic                  q_bit_o
);

    logic [STEP_WIDTH-1:0] neg_divisor;
    logic [STEP_WIDTH-1:0] diff;
    logic                  no_borrow;
    logic                  unused_diff_msb;

    assign neg_divisor = ~{1'b0, divisor_i};

    cla_adder #(
        .WIDTH (STEP_WIDTH)
    ) u_cla (
        .a_i    (minuend_i),
        .b_i    (neg_divisor),
        .cin_i  (1'b1),
        .sum_o  (diff),
        .cout_o (no_borrow)
    );

    // A successful step leaves a difference below the divisor, so bit 16 is zero.
    assign unused_diff_msb = diff[STEP_WIDTH-1];

    assign q_bit_o = no_borrow;
    assign rem_o   = no_borrow ? diff[DIV_WIDTH-1:0] : minuend_i[DIV_WIDTH-1:0];

endmodule

// File: rtl/div_seq_16bit.sv
// 16-bit unsigned sequential divider: one restoring step per clock, fixed latency.
module div_seq_16bit
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    div_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    word_t                rem_q, rem_d;
    word_t                dvd_q, dvd_d;
    word_t                dvs_q, dvs_d;
    word_t                quo_q, quo_d;
    word_t                rmd_q, rmd_d;
    logic                 dbz_q, dbz_d;

    logic [STEP_WIDTH-1:0] minuend;
    word_t                 step_rem;
    logic                  step_q_bit;
    word_t                 step_dvd;

    // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom.
    assign minuend  = {rem_q, dvd_q[DIV_WIDTH-1]};
    assign step_dvd = {dvd_q[DIV_WIDTH-2:0], step_q_bit};

    div_sub_step u_step (
        .minuend_i (minuend),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    quo_d   = step_dvd;
                    rmd_d   = step_rem;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; all registers, including operands, clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == DIV);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule
